msx_bus_cycle_engine: RTL

- Sits directly downstream of the filtered MSX cartridge bus input stage, which supplies synchronised, glitch-filtered ADDR/DIN/strobes.
- Turns raw strobe levels into single, qualified memory or I/O access transactions toward internal cartridge logic (ROM mapper, SCC, registers).
- Closes the loop back to the bus: DOUT, BUSDIR_n and WAIT_n.
- One transaction per Z80 bus cycle, with a valid/ack request handshake and a read-response channel.

---
 rtl/msx_bus_pkg.sv | 30 +++
 rtl/msx_strobe_edge.sv | 34 +++
 rtl/msx_bus_cycle_engine.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/msx_bus_pkg.sv
// Shared types for the MSX cartridge bus cycle engine: FSM states, access
// qualification codes and the idle data-bus value.
package msx_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_RESP  = 3'd2,
    ST_DRIVE = 3'd3,
    ST_DONE  = 3'd4
  } bus_state_e;

  typedef enum logic [1:0] {
    QUAL_NONE = 2'd0,
    QUAL_MEM  = 2'd1,
    QUAL_IO   = 2'd2
  } qual_e;

  localparam logic [7:0] DOUT_IDLE = 8'hFF;

  // IORQ together with M1 is an interrupt acknowledge, never an I/O access.
  function automatic qual_e qualify(input logic sltsl_n, input logic merq_n,
                                    input logic iorq_n, input logic m1_n,
                                    input logic rfsh_n);
    if (!sltsl_n && !merq_n && rfsh_n) return QUAL_MEM;
    if (!iorq_n && m1_n) return QUAL_IO;
    return QUAL_NONE;
  endfunction

endpackage

// File: rtl/msx_strobe_edge.sv
// Registers the filtered RD_n/WR_n strobes and produces single-cycle edge
// pulses plus a level flag that is high while both strobes are released.
module msx_strobe_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rd_n_i,
  input  logic wr_n_i,
  output logic rd_fall_o,
  output logic wr_fall_o,
  output logic rd_rise_o,
  output logic wr_rise_o,
  output logic released_o
);

  logic rd_q;
  logic wr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q <= 1'b1;
      wr_q <= 1'b1;
    end else begin
      rd_q <= rd_n_i;
      wr_q <= wr_n_i;
    end
  end

  assign rd_fall_o  = rd_q & ~rd_n_i;
  assign wr_fall_o  = wr_q & ~wr_n_i;
  assign rd_rise_o  = ~rd_q & rd_n_i;
  assign wr_rise_o  = ~wr_q & wr_n_i;
  assign released_o = rd_n_i & wr_n_i;

endmodule

// File: rtl/msx_bus_cycle_engine.sv
// Converts filtered MSX bus strobes into one qualified request per Z80 bus
// cycle and returns read data, BUSDIR_n and WAIT_n to the cartridge bus.
module msx_bus_cycle_engine
  import msx_bus_pkg::*;
#(
  parameter bit          WAIT_EN    = 1'b1,
  parameter int unsigned WAIT_DELAY = 4,
  parameter int unsigned WAIT_MAX   = 255,
  parameter int unsigned CNT_W      = 8
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic [15:0] BUS_ADDR,
  input  logic [7:0]  BUS_DIN,
  input  logic        BUS_SLTSL_n,
  input  logic        BUS_MERQ_n,
  input  logic        BUS_IORQ_n,
  input  logic        BUS_M1_n,
  input  logic        BUS_RFSH_n,
  input  logic        BUS_RD_n,
  input  logic        BUS_WR_n,
  output logic        REQ_VALID,
  input  logic        REQ_ACK,
  output logic        REQ_WR,
  output logic        REQ_IO,
  output logic [15:0] REQ_ADDR,
  output logic [7:0]  REQ_WDATA,
  input  logic        RSP_VALID,
  input  logic        RSP_HIT,
  input  logic [7:0]  RSP_DATA,
  output logic [7:0]  BUS_DOUT,
  output logic        BUS_BUSDIR_n,
  output logic        BUS_WAIT_n,
  output logic        BUSY
);

  localparam logic [CNT_W-1:0] DELAY_C = CNT_W'(WAIT_DELAY);
  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(WAIT_MAX);

  logic rd_fall, wr_fall, rd_rise, wr_rise, released;

  msx_strobe_edge u_edge (
    .clk_i      (CLK),
    .rst_ni     (RESET_n),
    .rd_n_i     (BUS_RD_n),
    .wr_n_i     (BUS_WR_n),
    .rd_fall_o  (rd_fall),
    .wr_fall_o  (wr_fall),
    .rd_rise_o  (rd_rise),
    .wr_rise_o  (wr_rise),
    .released_o (released)
  );

  bus_state_e        state_q, state_d;
  logic              armed_q, armed_d;
  logic              req_valid_q, req_valid_d;
  logic              req_wr_q, req_wr_d;
  logic              req_io_q, req_io_d;
  logic [15:0]       addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        dout_q, dout_d;
  logic              busdir_q, busdir_d;

  qual_e qual;
  logic  strobe_rise;
  logic  timeout;
  logic  waiting;

  assign qual        = qualify(BUS_SLTSL_n, BUS_MERQ_n, BUS_IORQ_n, BUS_M1_n, BUS_RFSH_n);
  assign strobe_rise = req_wr_q ? wr_rise : rd_rise;
  assign timeout     = !req_wr_q && (cnt_q == MAX_C);
  assign waiting     = (state_q == ST_REQ) || (state_q == ST_RESP);

  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q | released;
    req_valid_d = req_valid_q;
    req_wr_d    = req_wr_q;
    req_io_d    = req_io_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    dout_d      = dout_q;
    busdir_d    = busdir_q;

    if (waiting && (cnt_q != MAX_C)) cnt_d = cnt_q + CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        // Until both strobes have been seen released after reset, edges are
        // treated as belonging to a bus cycle already in flight.
        if (armed_q && (rd_fall || wr_fall)) begin
          if (qual != QUAL_NONE) begin
            state_d     = ST_REQ;
            req_valid_d = 1'b1;
            req_wr_d    = wr_fall;
            req_io_d    = (qual == QUAL_IO);
            addr_d      = BUS_ADDR;
            if (wr_fall) wdata_d = BUS_DIN;
            cnt_d       = '0;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_REQ: begin
        if (strobe_rise) begin
          req_valid_d = 1'b0;
          state_d     = ST_DONE;
        end else if (REQ_ACK) begin
          req_valid_d = 1'b0;
          if (req_wr_q) begin
            state_d = ST_DONE;
          end else if (RSP_VALID) begin
            state_d  = RSP_HIT ? ST_DRIVE : ST_DONE;
            dout_d   = RSP_HIT ? RSP_DATA : dout_q;
            busdir_d = !RSP_HIT;
          end else if (timeout) begin
            state_d  = ST_DRIVE;
            dout_d   = DOUT_IDLE;
            busdir_d = 1'b0;
          end else begin
            state_d = ST_RESP;
          end
        end else if (timeout) begin
          req_valid_d = 1'b0;
          state_d     = ST_DRIVE;
          dout_d      = DOUT_IDLE;
          busdir_d    = 1'b0;
        end
      end
      ST_RESP: begin
        if (rd_rise) begin
          state_d = ST_DONE;
        end else if (RSP_VALID) begin
          state_d  = RSP_HIT ? ST_DRIVE : ST_DONE;
          dout_d   = RSP_HIT ? RSP_DATA : dout_q;
          busdir_d = !RSP_HIT;
        end else if (timeout) begin
          state_d  = ST_DRIVE;
          dout_d   = DOUT_IDLE;
          busdir_d = 1'b0;
        end
      end
      ST_DRIVE: begin
        if (rd_rise) begin
          state_d  = ST_IDLE;
          busdir_d = 1'b1;
          dout_d   = DOUT_IDLE;
        end
      end
      ST_DONE: begin
        if (released) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q     <= ST_IDLE;
      armed_q     <= 1'b0;
      req_valid_q <= 1'b0;
      req_wr_q    <= 1'b0;
      req_io_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      dout_q      <= DOUT_IDLE;
      busdir_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      req_valid_q <= req_valid_d;
      req_wr_q    <= req_wr_d;
      req_io_q    <= req_io_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      dout_q      <= dout_d;
      busdir_q    <= busdir_d;
    end
  end

  // WAIT_n drops out at the saturation count so the Z80 is released on the
  // same count that forces the 8'hFF response.
  assign BUS_WAIT_n   = !(WAIT_EN && waiting && !req_wr_q &&
                          (cnt_q >= DELAY_C) && (cnt_q < MAX_C));
  assign REQ_VALID    = req_valid_q;
  assign REQ_WR       = req_wr_q;
  assign REQ_IO       = req_io_q;
  assign REQ_ADDR     = addr_q;
  assign REQ_WDATA    = wdata_q;
  assign BUS_DOUT     = dout_q;
  assign BUS_BUSDIR_n = busdir_q;
  assign BUSY         = (state_q != ST_IDLE);

endmodule
